fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction memory. It holds the program counter, drives the memory's enable and word address, and tracks the one-cycle synchronous read latency. It presents each returned instruction with its PC to decode over a valid/ready handshake, and accepts zero-bubble redirects from execute. Write enables toward the memory are tied inactive; this block only reads.

---
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency reads to the
// instruction memory, and hands each returned word plus its PC to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en_o,
  output logic [3:0]        imem_we_o,
  output logic [ADDR_W-1:0] imem_adr_o,
  input  logic [31:0]       imem_data_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              halt_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic              misalign_o,
  output logic [31:0]       fetch_cnt_o
);

  // Handshake toward decode: a beat transfers on a cycle where inst_valid_o
  // and inst_ready_i are both high; while valid is high and ready is low,
  // inst_o/pc_o are held stable and valid is not withdrawn, except when a
  // redirect kills the in-flight response.

  logic [31:0] pc_q, pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] fetch_pc;
  logic        accept;

  assign fetch_pc = redirect_i ? {redirect_pc_i[31:2], 2'b00} : pc_q;

  assign imem_en_o    = !rst && !halt_i && (!rsp_valid_q || inst_ready_i || redirect_i);
  assign imem_we_o    = 4'b0000;
  assign imem_adr_o   = fetch_pc[ADDR_W+1:2];
  assign inst_valid_o = rsp_valid_q && !redirect_i && !rst;
  assign inst_o       = imem_data_i;
  assign pc_o         = rsp_pc_q;
  assign misalign_o   = misalign_q;
  assign fetch_cnt_o  = cnt_q;

  assign accept = inst_valid_o && inst_ready_i;

  always_comb begin
    pc_d        = pc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    misalign_d  = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    cnt_d       = accept ? cnt_q + 32'd1 : cnt_q;
    if (imem_en_o) begin
      rsp_pc_d    = fetch_pc;
      pc_d        = fetch_pc + 32'd4;
      rsp_valid_d = 1'b1;
    end else if (redirect_i) begin
      // Redirect during halt: remember the target, drop the stale response.
      pc_d        = fetch_pc;
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= RESET_PC;
      misalign_q  <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      misalign_q  <= misalign_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle inputs and expected
// outputs, plus hand sequences for mid-run reset and 32-bit PC wrap.
module tb_fetch_unit;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic              imem_en_o;
  logic [3:0]        imem_we_o;
  logic [ADDR_W-1:0] imem_adr_o;
  logic [31:0]       imem_data_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              halt_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [31:0]       inst_o;
  logic [31:0]       pc_o;
  logic              misalign_o;
  logic [31:0]       fetch_cnt_o;

  int tests_run;
  int tests_failed;

  fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en_o     (imem_en_o),
    .imem_we_o     (imem_we_o),
    .imem_adr_o    (imem_adr_o),
    .imem_data_i   (imem_data_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .misalign_o    (misalign_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  // Clock and memory model: word n holds 0x1000_0000 + n, one-cycle read.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_q;
  initial mem_q = 32'd0;
  always @(posedge clk) if (imem_en_o) mem_q <= 32'h1000_0000 + {20'd0, imem_adr_o};
  assign imem_data_i = mem_q;

  typedef struct {
    logic              redirect;
    logic [31:0]       rpc;
    logic              halt;
    logic              ready;
    logic              en;
    logic [ADDR_W-1:0] adr;
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              mis;
    logic [31:0]       cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] rpc, input logic h, input logic rdy);
    @(negedge clk);
    rst           = 1'b0;
    redirect_i    = r;
    redirect_pc_i = rpc;
    halt_i        = h;
    inst_ready_i  = rdy;
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [31:0] rpc, input logic h,
                              input logic rdy, input logic en, input logic [ADDR_W-1:0] adr,
                              input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic mis, input logic [31:0] cnt);
    vec_t t;
    t.redirect = r;  t.rpc = rpc;  t.halt = h;  t.ready = rdy;
    t.en = en;  t.adr = adr;  t.valid = v;  t.pc = pc;  t.inst = inst;
    t.mis = mis;  t.cnt = cnt;
    return t;
  endfunction

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    halt_i        = 1'b0;
    inst_ready_i  = 1'b0;

    //               red rpc            h  rdy en adr     v  pc            inst           mis cnt
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h000, 0, 32'h0,        32'h0,         0, 0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h001, 1, 32'h0,        32'h1000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h002, 1, 32'h4,        32'h1000_0001, 0, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 12'h003, 1, 32'h8,        32'h1000_0002, 0, 2));
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 12'h003, 1, 32'h8,        32'h1000_0002, 0, 2));
    vecs.push_back(mk(0, 32'h0,         0, 0, 0, 12'h003, 1, 32'h8,        32'h1000_0002, 0, 2));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h003, 1, 32'h8,        32'h1000_0002, 0, 2));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h004, 1, 32'hC,        32'h1000_0003, 0, 3));
    vecs.push_back(mk(1, 32'h100,       0, 1, 1, 12'h040, 0, 32'h0,        32'h0,         0, 4));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h041, 1, 32'h100,      32'h1000_0040, 0, 4));
    vecs.push_back(mk(1, 32'h102,       0, 1, 1, 12'h040, 0, 32'h0,        32'h0,         0, 5));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h041, 1, 32'h100,      32'h1000_0040, 1, 5));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h042, 1, 32'h104,      32'h1000_0041, 0, 6));
    vecs.push_back(mk(1, 32'h3FF8,      0, 1, 1, 12'hFFE, 0, 32'h0,        32'h0,         0, 7));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'hFFF, 1, 32'h3FF8,     32'h1000_0FFE, 0, 7));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h000, 1, 32'h3FFC,     32'h1000_0FFF, 0, 8));
    vecs.push_back(mk(0, 32'h0,         1, 0, 0, 12'h001, 1, 32'h4000,     32'h1000_0000, 0, 9));
    vecs.push_back(mk(0, 32'h0,         1, 0, 0, 12'h001, 1, 32'h4000,     32'h1000_0000, 0, 9));
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 12'h001, 1, 32'h4000,     32'h1000_0000, 0, 9));
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 12'h001, 0, 32'h0,        32'h0,         0, 10));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h001, 0, 32'h0,        32'h0,         0, 10));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h002, 1, 32'h4004,     32'h1000_0001, 0, 10));
    vecs.push_back(mk(1, 32'h200,       1, 1, 0, 12'h080, 0, 32'h0,        32'h0,         0, 11));
    vecs.push_back(mk(0, 32'h0,         1, 1, 0, 12'h080, 0, 32'h0,        32'h0,         0, 11));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h080, 0, 32'h0,        32'h0,         0, 11));
    vecs.push_back(mk(0, 32'h0,         0, 1, 1, 12'h081, 1, 32'h200,      32'h1000_0080, 0, 11));

    // Reset state after two reset edges.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_en",    {31'd0, imem_en_o},    32'd0);
    check("rst_we",    {28'd0, imem_we_o},    32'd0);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_pc",    pc_o,                  32'h0);
    check("rst_mis",   {31'd0, misalign_o},   32'd0);
    check("rst_cnt",   fetch_cnt_o,           32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].redirect, vecs[i].rpc, vecs[i].halt, vecs[i].ready);
      check($sformatf("v%0d_en", i),    {31'd0, imem_en_o},    {31'd0, vecs[i].en});
      check($sformatf("v%0d_we", i),    {28'd0, imem_we_o},    32'd0);
      check($sformatf("v%0d_adr", i),   {20'd0, imem_adr_o},   {20'd0, vecs[i].adr});
      check($sformatf("v%0d_valid", i), {31'd0, inst_valid_o}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d_mis", i),   {31'd0, misalign_o},   {31'd0, vecs[i].mis});
      check($sformatf("v%0d_cnt", i),   fetch_cnt_o,           vecs[i].cnt);
      if (vecs[i].valid) begin
        check($sformatf("v%0d_pc", i),   pc_o,   vecs[i].pc);
        check($sformatf("v%0d_inst", i), inst_o, vecs[i].inst);
      end
    end

    // Mid-run reset with a valid response pending (pc 0x204).
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("mrst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("mrst_en",    {31'd0, imem_en_o},    32'd0);
    check("mrst_pc",    pc_o,                  32'h0);
    check("mrst_cnt",   fetch_cnt_o,           32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_en",    {31'd0, imem_en_o},    32'd1);
    check("post_rst_adr",   {20'd0, imem_adr_o},   32'd0);
    check("post_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("post_rst_v1",   {31'd0, inst_valid_o}, 32'd1);
    check("post_rst_pc1",  pc_o,                  32'h0);
    check("post_rst_inst", inst_o,                32'h1000_0000);

    // PC wraps 0xFFFF_FFFC -> 0.
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    check("wrap_adr",   {20'd0, imem_adr_o},   32'h0000_0FFF);
    check("wrap_valid", {31'd0, inst_valid_o}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("wrap_pc",    pc_o,                  32'hFFFF_FFFC);
    check("wrap_inst",  inst_o,                32'h1000_0FFF);
    check("wrap_next",  {20'd0, imem_adr_o},   32'd0);
    check("wrap_cnt",   fetch_cnt_o,           32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
